// File: rtl/regfile_wb_pkg.sv
// Shared constants, request record and helpers for the regfile writeback sequencer.
package regfile_wb_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 65;
    localparam int LANES  = 4;
    localparam int DEPTH  = 16;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LCNT_W = $clog2(LANES) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    function automatic logic [LCNT_W-1:0] popcount(input logic [LANES-1:0] v);
        logic [LCNT_W-1:0] n;
        n = {LCNT_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            n = n + LCNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_wb_select.sv
// Picks the longest in-order prefix of the oldest FIFO entries that can be
// written this cycle without two writes to the same register.
module regfile_wb_select
    import regfile_wb_pkg::*;
(
    input  logic [ADDR_W-1:0] cand_addr [LANES],
    input  logic [CNT_W-1:0]  count,
    input  logic              drain_stall,
    output logic [LANES-1:0]  sel,
    output logic [LCNT_W-1:0] deq_n
);

    logic blocked_s;
    logic ok_s;

    // The first candidate that cannot go blocks every younger one.
    always_comb begin
        sel       = {LANES{1'b0}};
        blocked_s = drain_stall;
        ok_s      = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            ok_s = !blocked_s && (CNT_W'(k) < count);
            for (int j = 0; j < LANES; j++) begin
                if (j < k && sel[j] && (cand_addr[j] == cand_addr[k])) begin
                    ok_s = 1'b0;
                end else begin
                    ok_s = ok_s;
                end
            end
            sel[k] = ok_s;
            if (!ok_s) begin
                blocked_s = 1'b1;
            end else begin
                blocked_s = blocked_s;
            end
        end
        deq_n = popcount(sel);
    end

endmodule

// File: rtl/regfile_wb_sequencer.sv
// Buffers up to LANES writeback requests per cycle in program order and drains
// up to LANES of them per cycle onto the regfile write ports.
module regfile_wb_sequencer
    import regfile_wb_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [LANES-1:0]          enq_valid,
    input  logic [LANES*ADDR_W-1:0]   enq_addr,
    input  logic [LANES*DATA_W-1:0]   enq_data,
    output logic                      enq_ready,
    input  logic                      drain_stall,
    output logic [ADDR_W-1:0]         W0_addr,
    output logic [ADDR_W-1:0]         W1_addr,
    output logic [ADDR_W-1:0]         W2_addr,
    output logic [ADDR_W-1:0]         W3_addr,
    output logic                      W0_en,
    output logic                      W1_en,
    output logic                      W2_en,
    output logic                      W3_en,
    output logic [DATA_W-1:0]         W0_data,
    output logic [DATA_W-1:0]         W1_data,
    output logic [DATA_W-1:0]         W2_data,
    output logic [DATA_W-1:0]         W3_data,
    output logic [CNT_W-1:0]          count,
    output logic                      empty
);

    wb_req_t           mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    wb_req_t           req_s      [LANES];
    logic [PTR_W-1:0]  wr_idx_s   [LANES];
    logic [LANES-1:0]  wr_en_s;
    logic [PTR_W-1:0]  wr_off_s;
    wb_req_t           cand_s     [LANES];
    logic [ADDR_W-1:0] cand_addr_s[LANES];
    logic [LANES-1:0]  sel_s;
    logic [LCNT_W-1:0] deq_n_s;
    logic [LCNT_W-1:0] enq_n_s;
    logic              enq_ready_s;

    // Ready looks only at the registered count so it never depends on drain.
    assign enq_ready_s = (count_q <= CNT_W'(DEPTH - LANES));
    assign enq_n_s     = popcount(enq_valid & {LANES{enq_ready_s}});

    // Compact accepted lanes onto consecutive slots starting at tail.
    always_comb begin
        wr_off_s = {PTR_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            req_s[i].addr = enq_addr[i*ADDR_W +: ADDR_W];
            req_s[i].data = enq_data[i*DATA_W +: DATA_W];
            wr_en_s[i]    = enq_valid[i] && enq_ready_s;
            wr_idx_s[i]   = tail_q + wr_off_s;
            if (wr_en_s[i]) begin
                wr_off_s = wr_off_s + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                wr_off_s = wr_off_s;
            end
        end
    end

    // Candidate window is the oldest LANES slots; index arithmetic wraps.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            cand_s[k]      = mem_q[head_q + PTR_W'(k)];
            cand_addr_s[k] = cand_s[k].addr;
        end
    end

    regfile_wb_select u_select (
        .cand_addr   (cand_addr_s),
        .count       (count_q),
        .drain_stall (drain_stall),
        .sel         (sel_s),
        .deq_n       (deq_n_s)
    );

    // Pointer and occupancy next-state.
    always_comb begin
        head_d  = head_q + PTR_W'(deq_n_s);
        tail_d  = tail_q + PTR_W'(enq_n_s);
        count_d = count_q + CNT_W'(enq_n_s) - CNT_W'(deq_n_s);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents survive reset and are masked by count.
    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en_s[i]) begin
                mem_q[wr_idx_s[i]] <= req_s[i];
            end
        end
    end

    assign W0_addr   = cand_s[0].addr;
    assign W1_addr   = cand_s[1].addr;
    assign W2_addr   = cand_s[2].addr;
    assign W3_addr   = cand_s[3].addr;
    assign W0_data   = cand_s[0].data;
    assign W1_data   = cand_s[1].data;
    assign W2_data   = cand_s[2].data;
    assign W3_data   = cand_s[3].data;
    assign W0_en     = sel_s[0];
    assign W1_en     = sel_s[1];
    assign W2_en     = sel_s[2];
    assign W3_en     = sel_s[3];
    assign enq_ready = enq_ready_s;
    assign count     = count_q;
    assign empty     = (count_q == {CNT_W{1'b0}});

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Bench for regfile_wb_sequencer: directed vector table, hand-written corner
// sequences and random traffic checked against a queue-based reference.
module tb_regfile_wb_sequencer;
    import regfile_wb_pkg::*;

    logic                    clock = 1'b0;
    logic                    reset_n = 1'b0;
    logic [LANES-1:0]        enq_valid = '0;
    logic [LANES*ADDR_W-1:0] enq_addr = '0;
    logic [LANES*DATA_W-1:0] enq_data = '0;
    logic                    drain_stall = 1'b0;
    logic                    enq_ready;
    logic [LANES-1:0]        w_en;
    logic [ADDR_W-1:0]       w_addr [LANES];
    logic [DATA_W-1:0]       w_data [LANES];
    logic [CNT_W-1:0]        count;
    logic                    empty;

    int n_checks = 0;
    int n_fail   = 0;

    wb_req_t           mq[$];
    logic [DATA_W-1:0] model_rf [128];
    logic [DATA_W-1:0] dut_rf   [128];

    typedef struct {
        logic [LANES-1:0]        v;
        logic [LANES*ADDR_W-1:0] a;
        logic [LANES*DATA_W-1:0] d;
        logic                    st;
        logic [LANES-1:0]        exp_en;
        logic [LANES*ADDR_W-1:0] exp_a;
        logic [LANES*DATA_W-1:0] exp_d;
        logic [CNT_W-1:0]        exp_cnt;
    } vec_t;

    vec_t tbl [9];

    always #5 clock = ~clock;

    regfile_wb_sequencer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enq_valid   (enq_valid),
        .enq_addr    (enq_addr),
        .enq_data    (enq_data),
        .enq_ready   (enq_ready),
        .drain_stall (drain_stall),
        .W0_addr     (w_addr[0]),
        .W1_addr     (w_addr[1]),
        .W2_addr     (w_addr[2]),
        .W3_addr     (w_addr[3]),
        .W0_en       (w_en[0]),
        .W1_en       (w_en[1]),
        .W2_en       (w_en[2]),
        .W3_en       (w_en[3]),
        .W0_data     (w_data[0]),
        .W1_data     (w_data[1]),
        .W2_data     (w_data[2]),
        .W3_data     (w_data[3]),
        .count       (count),
        .empty       (empty)
    );

    function automatic logic [LANES*ADDR_W-1:0] pa4(input int a0, input int a1, input int a2, input int a3);
        return {ADDR_W'(a3), ADDR_W'(a2), ADDR_W'(a1), ADDR_W'(a0)};
    endfunction

    function automatic logic [LANES*DATA_W-1:0] pd4(input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                                                   input logic [DATA_W-1:0] d2, input logic [DATA_W-1:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic [LANES-1:0] v, input logic [LANES*ADDR_W-1:0] a,
                         input logic [LANES*DATA_W-1:0] d, input logic st);
        enq_valid   = v;
        enq_addr    = a;
        enq_data    = d;
        drain_stall = st;
        #1;
    endtask

    // Reference: oldest entries go in order, stopping at stall, end of queue or a repeated address.
    task automatic advance();
        int  n;
        bit  stop;
        bit  exp_ready;
        wb_req_t t;
        n    = 0;
        stop = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (!stop) begin
                if (drain_stall || k >= mq.size()) begin
                    stop = 1'b1;
                end else begin
                    for (int j = 0; j < k; j++) begin
                        if (mq[j].addr == mq[k].addr) stop = 1'b1;
                    end
                    if (!stop) n++;
                end
            end
        end
        exp_ready = (DEPTH - mq.size()) >= LANES;
        chk("enq_ready", DATA_W'(enq_ready), DATA_W'(exp_ready));
        chk("count", DATA_W'(count), DATA_W'(mq.size()));
        chk("empty", DATA_W'(empty), DATA_W'(mq.size() == 0));
        for (int k = 0; k < LANES; k++) begin
            chk($sformatf("W%0d_en", k), DATA_W'(w_en[k]), DATA_W'(k < n));
            if (k < n) begin
                chk($sformatf("W%0d_addr", k), DATA_W'(w_addr[k]), DATA_W'(mq[k].addr));
                chk($sformatf("W%0d_data", k), w_data[k], mq[k].data);
            end
        end
        for (int k = 0; k < LANES; k++) begin
            if (w_en[k] === 1'b1) dut_rf[w_addr[k]] = w_data[k];
        end
        for (int k = 0; k < n; k++) begin
            t = mq.pop_front();
            model_rf[t.addr] = t.data;
        end
        if (exp_ready) begin
            for (int i = 0; i < LANES; i++) begin
                if (enq_valid[i]) begin
                    t.addr = enq_addr[i*ADDR_W +: ADDR_W];
                    t.data = enq_data[i*DATA_W +: DATA_W];
                    mq.push_back(t);
                end
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drain_all();
        int guard;
        guard = 0;
        while (mq.size() != 0 && guard < 100) begin
            drive('0, '0, '0, 1'b0);
            advance();
            guard++;
        end
        chk("drain_bound", DATA_W'(guard < 100), DATA_W'(1));
    endtask

    localparam logic [DATA_W-1:0] DA  = 65'h1_0000_0000_0000_00AA;
    localparam logic [DATA_W-1:0] CA  = 65'h0_AAAA_0000_0000_0001;
    localparam logic [DATA_W-1:0] CB  = 65'h1_BBBB_0000_0000_0002;
    localparam logic [DATA_W-1:0] CC  = 65'h0_CCCC_0000_0000_0003;
    localparam logic [DATA_W-1:0] CD  = 65'h1_DDDD_0000_0000_0004;
    localparam logic [DATA_W-1:0] Z   = 65'h0;

    initial begin
        logic [LANES*ADDR_W-1:0] ra;
        logic [LANES*DATA_W-1:0] rd;
        for (int i = 0; i < 128; i++) begin
            model_rf[i] = '0;
            dut_rf[i]   = '0;
        end

        tbl[0] = '{4'b0100, pa4(0,0,5,0), pd4(Z,Z,DA,Z), 1'b0, 4'b0000, '0, '0, 5'd0};
        tbl[1] = '{4'b0000, '0, '0, 1'b0, 4'b0001, pa4(5,0,0,0), pd4(DA,Z,Z,Z), 5'd1};
        tbl[2] = '{4'b1111, pa4(1,2,3,4), pd4(65'h11,65'h22,65'h33,65'h44), 1'b0, 4'b0000, '0, '0, 5'd0};
        tbl[3] = '{4'b0000, '0, '0, 1'b0, 4'b1111, pa4(1,2,3,4), pd4(65'h11,65'h22,65'h33,65'h44), 5'd4};
        tbl[4] = '{4'b1111, pa4(7,7,9,7), pd4(CA,CB,CC,CD), 1'b0, 4'b0000, '0, '0, 5'd0};
        tbl[5] = '{4'b0000, '0, '0, 1'b0, 4'b0001, pa4(7,0,0,0), pd4(CA,Z,Z,Z), 5'd4};
        tbl[6] = '{4'b0000, '0, '0, 1'b0, 4'b0011, pa4(7,9,0,0), pd4(CB,CC,Z,Z), 5'd3};
        tbl[7] = '{4'b0000, '0, '0, 1'b0, 4'b0001, pa4(7,0,0,0), pd4(CD,Z,Z,Z), 5'd1};
        tbl[8] = '{4'b0000, '0, '0, 1'b0, 4'b0000, '0, '0, 5'd0};

        repeat (3) @(negedge clock);
        #1;
        chk("rst_ready", DATA_W'(enq_ready), DATA_W'(1));
        chk("rst_empty", DATA_W'(empty), DATA_W'(1));
        chk("rst_count", DATA_W'(count), DATA_W'(0));
        chk("rst_en", DATA_W'(w_en), DATA_W'(0));
        reset_n = 1'b1;
        @(negedge clock);

        // Directed vector table: single request, full group, address collision.
        for (int r = 0; r < 9; r++) begin
            drive(tbl[r].v, tbl[r].a, tbl[r].d, tbl[r].st);
            chk($sformatf("tbl%0d_count", r), DATA_W'(count), DATA_W'(tbl[r].exp_cnt));
            for (int k = 0; k < LANES; k++) begin
                chk($sformatf("tbl%0d_W%0d_en", r, k), DATA_W'(w_en[k]), DATA_W'(tbl[r].exp_en[k]));
                if (tbl[r].exp_en[k]) begin
                    chk($sformatf("tbl%0d_W%0d_addr", r, k), DATA_W'(w_addr[k]), DATA_W'(tbl[r].exp_a[k*ADDR_W +: ADDR_W]));
                    chk($sformatf("tbl%0d_W%0d_data", r, k), w_data[k], tbl[r].exp_d[k*DATA_W +: DATA_W]);
                end
            end
            advance();
        end
        chk("rf_addr7", dut_rf[7], CD);
        chk("rf_addr9", dut_rf[9], CC);
        chk("rf_addr5", dut_rf[5], DA);

        // Reset while a group is being drained.
        drive(4'b1111, pa4(40,41,42,43), '0, 1'b0);
        advance();
        drive('0, '0, '0, 1'b0);
        chk("pre_rst_en", DATA_W'(w_en), DATA_W'(4'b1111));
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_en", DATA_W'(w_en), DATA_W'(0));
        chk("midrst_count", DATA_W'(count), DATA_W'(0));
        chk("midrst_empty", DATA_W'(empty), DATA_W'(1));
        mq.delete();
        @(negedge clock);
        reset_n = 1'b1;

        // Fill to 16 under stall, refuse a fifth group, then drain with wrap.
        for (int g = 0; g < 4; g++) begin
            rd = pd4(DATA_W'(100 + 4*g), DATA_W'(101 + 4*g), DATA_W'(102 + 4*g), DATA_W'(103 + 4*g));
            drive(4'b1111, pa4(16+4*g, 17+4*g, 18+4*g, 19+4*g), rd, 1'b1);
            advance();
        end
        drive(4'b1111, pa4(60,61,62,63), '0, 1'b1);
        chk("full_ready", DATA_W'(enq_ready), DATA_W'(0));
        chk("full_count", DATA_W'(count), DATA_W'(16));
        advance();
        drive('0, '0, '0, 1'b0);
        chk("full_hold", DATA_W'(count), DATA_W'(16));
        chk("drain_W0", DATA_W'(w_addr[0]), DATA_W'(16));
        advance();
        for (int g = 0; g < 2; g++) begin
            ra = pa4(32+4*g, 33+4*g, 34+4*g, 35+4*g);
            drive(4'b1111, ra, pd4(65'h5, 65'h6, 65'h7, 65'h8), 1'b0);
            chk("simul_ready", DATA_W'(enq_ready), DATA_W'(1));
            chk("simul_count", DATA_W'(count), DATA_W'(12));
            advance();
        end
        drive('0, '0, '0, 1'b0);
        chk("simul_after", DATA_W'(count), DATA_W'(12));
        drain_all();

        // Random traffic with narrow address range to provoke collisions.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < LANES; i++) begin
                ra[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 7));
                rd[i*DATA_W +: DATA_W] = DATA_W'({$urandom(), $urandom(), $urandom()});
            end
            drive(LANES'($urandom_range(0, 15)), ra, rd, ($urandom_range(0, 3) == 0));
            advance();
        end
        drain_all();
        for (int i = 0; i < 128; i++) begin
            chk($sformatf("rf_final_%0d", i), dut_rf[i], model_rf[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
